// File: rtl/song_sequencer.sv
// Song ROM sequencer: fetches note words from a synchronous-read ROM and presents
// each one on a registered three-voice note bus for a programmed number of tempo ticks.
module song_sequencer #(
   parameter int ADDR_W   = 8,
   parameter int TICK_DIV = 250000,
   parameter int DUR_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              play,
   input  logic              restart,
   input  logic              loop_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [27+DUR_W:0] mem_data,
   output logic [26:0]       notes,
   output logic              beat,
   output logic              playing,
   output logic              done
);

   localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LOAD  = 3'd2,
      HOLD  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  addr_d;
   logic [26:0]        notes_d;
   logic [26:0]        word_q, word_d;
   logic [DUR_W-1:0]   dur_q, dur_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic               beat_d, done_d, playing_d;

   function automatic logic word_end(input logic [27+DUR_W:0] w);
      return w[27+DUR_W];
   endfunction

   function automatic logic [DUR_W-1:0] word_dur(input logic [27+DUR_W:0] w);
      return w[26+DUR_W:27];
   endfunction

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      return a + ADDR_W'(1);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         mem_addr <= '0;
         notes    <= '0;
         word_q   <= '0;
         dur_q    <= '0;
         presc_q  <= '0;
         beat     <= 1'b0;
         done     <= 1'b0;
         playing  <= 1'b0;
      end else begin
         state_q  <= state_d;
         mem_addr <= addr_d;
         notes    <= notes_d;
         word_q   <= word_d;
         dur_q    <= dur_d;
         presc_q  <= presc_d;
         beat     <= beat_d;
         done     <= done_d;
         playing  <= playing_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = mem_addr;
      notes_d = notes;
      word_d  = word_q;
      dur_d   = dur_q;
      presc_d = presc_q;
      beat_d  = 1'b0;
      done_d  = done;

      if (restart) begin
         state_d = play ? FETCH : IDLE;
         addr_d  = '0;
         notes_d = '0;
         word_d  = '0;
         dur_d   = '0;
         presc_d = '0;
         done_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (play) state_d = FETCH;
            end
            FETCH: begin
               if (play) state_d = LOAD;
            end
            // ROM output is valid here; a paused LOAD simply re-evaluates next cycle.
            LOAD: begin
               if (play) begin
                  if (word_end(mem_data)) begin
                     if (loop_en) begin
                        addr_d  = '0;
                        state_d = FETCH;
                     end else begin
                        notes_d = '0;
                        done_d  = 1'b1;
                        state_d = DONE;
                     end
                  end else if (word_dur(mem_data) == '0) begin
                     addr_d  = next_addr(mem_addr);
                     state_d = FETCH;
                  end else begin
                     notes_d = mem_data[26:0];
                     word_d  = mem_data[26:0];
                     dur_d   = word_dur(mem_data);
                     presc_d = '0;
                     beat_d  = 1'b1;
                     addr_d  = next_addr(mem_addr);
                     state_d = HOLD;
                  end
               end
            end
            // Pause mutes the bus but keeps word_q and both counters frozen.
            HOLD: begin
               if (play) begin
                  notes_d = word_q;
                  if (presc_q == PRESC_LAST) begin
                     presc_d = '0;
                     dur_d   = dur_q - DUR_W'(1);
                     if (dur_q == DUR_W'(1)) state_d = FETCH;
                  end else begin
                     presc_d = presc_q + PRESC_W'(1);
                  end
               end else begin
                  notes_d = '0;
               end
            end
            DONE: begin
               notes_d = '0;
               done_d  = 1'b1;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      playing_d = play && ((state_d == FETCH) || (state_d == LOAD) || (state_d == HOLD));
   end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with an event-level song model checked every cycle.
module tb_song_sequencer;

   localparam int AW = 4;
   localparam int TD = 4;
   localparam int DW = 8;
   localparam int MW = 28 + DW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          play = 1'b0;
   logic          restart = 1'b0;
   logic          loop_en = 1'b0;
   logic [AW-1:0] mem_addr;
   logic [MW-1:0] mem_data = '0;
   logic [26:0]   notes;
   logic          beat, playing, done;

   logic [MW-1:0] rom [16];

   int n_cmp = 0;
   int n_err = 0;

   song_sequencer #(.ADDR_W(AW), .TICK_DIV(TD), .DUR_W(DW)) dut (
      .clk(clk), .rst(rst), .play(play), .restart(restart), .loop_en(loop_en),
      .mem_addr(mem_addr), .mem_data(mem_data), .notes(notes),
      .beat(beat), .playing(playing), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) mem_data <= rom[mem_addr];

   function automatic logic [MW-1:0] w(input logic e, input logic [DW-1:0] d, input logic [26:0] n);
      return {e, d, n};
   endfunction

   // Model: m_phase 0 waiting for play, 1 fetching (m_wait active cycles until the
   // word acts), 2 sounding (m_left active cycles remaining), 3 finished.
   int          m_phase = 0, m_wait = 0, m_left = 0, m_addr = 0;
   logic [26:0] m_word = '0, m_notes = '0;
   logic        m_beat = 1'b0, m_done = 1'b0, m_play = 1'b0;
   logic [MW-1:0] ent;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0; m_wait = 0; m_left = 0; m_addr = 0;
         m_word = '0; m_notes = '0; m_beat = 1'b0; m_done = 1'b0; m_play = 1'b0;
      end else begin
         m_beat = 1'b0;
         if (restart) begin
            m_addr = 0; m_notes = '0; m_done = 1'b0; m_left = 0;
            m_phase = play ? 1 : 0; m_wait = 2;
         end else begin
            case (m_phase)
               0: if (play) begin m_phase = 1; m_wait = 2; end
               1: if (play) begin
                  m_wait = m_wait - 1;
                  if (m_wait == 0) begin
                     ent = rom[m_addr];
                     if (ent[MW-1] && loop_en) begin
                        m_addr = 0; m_wait = 2;
                     end else if (ent[MW-1]) begin
                        m_notes = '0; m_done = 1'b1; m_phase = 3;
                     end else if (ent[MW-2:27] == 0) begin
                        m_addr = (m_addr + 1) % 16; m_wait = 2;
                     end else begin
                        m_word = ent[26:0]; m_notes = m_word; m_beat = 1'b1;
                        m_addr = (m_addr + 1) % 16;
                        m_left = int'(ent[MW-2:27]) * TD; m_phase = 2;
                     end
                  end
               end
               2: if (play) begin
                  m_notes = m_word;
                  m_left = m_left - 1;
                  if (m_left == 0) begin m_phase = 1; m_wait = 2; end
               end else begin
                  m_notes = '0;
               end
               default: ;
            endcase
         end
         m_play = play && (m_phase == 1 || m_phase == 2);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock: compare against the model mid-cycle, then return just after the next edge.
   task automatic cyc();
      @(negedge clk);
      chk("model.notes", 32'(notes), 32'(m_notes));
      chk("model.mem_addr", 32'(mem_addr), 32'(m_addr[3:0]));
      chk("model.beat", 32'(beat), 32'(m_beat));
      chk("model.playing", 32'(playing), 32'(m_play));
      chk("model.done", 32'(done), 32'(m_done));
      @(posedge clk);
      #1;
   endtask

   task automatic next_beat(input int lim, output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!beat && n < lim);
      if (!beat) begin
         n_cmp++;
         n_err++;
         $display("FAIL beat_timeout: no beat within %0d cycles", lim);
      end
   endtask

   task automatic stop_song();
      play = 1'b0;
      restart = 1'b1;
      cyc();
      restart = 1'b0;
      cyc();
   endtask

   initial begin
      int n;
      logic wrapped;
      logic [3:0] prev;
      logic [26:0] wrap_notes;

      for (int i = 0; i < 16; i++) rom[i] = '0;
      rst = 1'b1;
      repeat (3) cyc();
      chk("reset.notes", 32'(notes), 32'h0);
      chk("reset.mem_addr", 32'(mem_addr), 32'h0);
      chk("reset.flags", {29'b0, beat, playing, done}, 32'h0);
      rst = 1'b0;
      cyc();

      // Basic play then non-looping end of song.
      rom[0] = w(1'b0, 8'd3, 27'h0000081);
      rom[1] = w(1'b0, 8'd2, 27'h0000102);
      rom[2] = w(1'b1, 8'd0, 27'h0);
      loop_en = 1'b0;
      play = 1'b1;
      next_beat(10, n);
      chk("basic.latency", n, 3);
      chk("basic.notes", 32'(notes), 32'h81);
      chk("basic.mem_addr", 32'(mem_addr), 32'd1);
      next_beat(40, n);
      chk("basic.note_cycles", n, 14);
      chk("basic.notes2", 32'(notes), 32'h102);
      n = 0;
      while (!done && n < 30) begin cyc(); n++; end
      chk("end.cycles", n, 10);
      chk("end.done", 32'(done), 32'd1);
      chk("end.notes", 32'(notes), 32'h0);
      chk("end.mem_addr", 32'(mem_addr), 32'd2);
      repeat (3) cyc();

      // Looping: restart from DONE, song wraps back to ROM[0].
      loop_en = 1'b1;
      restart = 1'b1;
      cyc();
      restart = 1'b0;
      chk("restart.notes", 32'(notes), 32'h0);
      chk("restart.mem_addr", 32'(mem_addr), 32'd0);
      chk("restart.done", 32'(done), 32'd0);
      next_beat(10, n);
      chk("loop.reload_edges", n, 2);
      next_beat(40, n);
      next_beat(40, n);
      chk("loop.gap", n, 12);
      chk("loop.notes", 32'(notes), 32'h81);
      chk("loop.mem_addr", 32'(mem_addr), 32'd1);

      // Pause after five cycles of a dur-3 note.
      restart = 1'b1;
      cyc();
      restart = 1'b0;
      next_beat(10, n);
      repeat (4) cyc();
      play = 1'b0;
      cyc();
      chk("pause.notes", 32'(notes), 32'h0);
      chk("pause.playing", 32'(playing), 32'd0);
      repeat (9) cyc();
      play = 1'b1;
      cyc();
      chk("resume.notes", 32'(notes), 32'h81);
      next_beat(40, n);
      chk("pause.remaining", n, 9);
      chk("pause.next", 32'(notes), 32'h102);

      // Restart during HOLD at address 3.
      stop_song();
      rom[0] = w(1'b0, 8'd1, 27'h0000081);
      rom[1] = w(1'b0, 8'd1, 27'h0000102);
      rom[2] = w(1'b0, 8'd3, 27'h00001FF);
      rom[3] = w(1'b1, 8'd0, 27'h0);
      play = 1'b1;
      repeat (3) next_beat(20, n);
      chk("rs.addr3", 32'(mem_addr), 32'd3);
      repeat (2) cyc();
      restart = 1'b1;
      cyc();
      restart = 1'b0;
      chk("rs.notes", 32'(notes), 32'h0);
      chk("rs.mem_addr", 32'(mem_addr), 32'd0);
      next_beat(10, n);
      chk("rs.reload_edges", n, 2);
      chk("rs.reload_notes", 32'(notes), 32'h81);

      // Zero-duration word at address 1 is skipped.
      stop_song();
      rom[1] = w(1'b0, 8'd0, 27'h0000155);
      rom[2] = w(1'b0, 8'd1, 27'h00000AA);
      play = 1'b1;
      next_beat(10, n);
      next_beat(20, n);
      chk("skip.gap", n, 8);
      chk("skip.notes", 32'(notes), 32'hAA);
      chk("skip.mem_addr", 32'(mem_addr), 32'd3);

      // Sixteen words, no end flag: address wraps 15 -> 0.
      stop_song();
      for (int i = 0; i < 16; i++) rom[i] = w(1'b0, 8'd1, 27'(i + 1));
      play = 1'b1;
      wrapped = 1'b0;
      wrap_notes = '0;
      prev = mem_addr;
      n = 0;
      while (!wrapped && n < 200) begin
         cyc();
         n++;
         if (prev == 4'd15 && mem_addr == 4'd0) begin
            wrapped = 1'b1;
            wrap_notes = notes;
         end
         prev = mem_addr;
      end
      chk("wrap.seen", 32'(wrapped), 32'd1);
      chk("wrap.notes", 32'(wrap_notes), 32'd16);
      next_beat(20, n);
      chk("wrap.gap", n, 6);
      chk("wrap.first", 32'(notes), 32'd1);

      // Asynchronous reset mid-HOLD.
      cyc();
      rst = 1'b1;
      #1;
      chk("arst.notes", 32'(notes), 32'h0);
      chk("arst.mem_addr", 32'(mem_addr), 32'h0);
      chk("arst.flags", {29'b0, beat, playing, done}, 32'h0);
      cyc();
      rst = 1'b0;
      next_beat(10, n);
      chk("arst.latency", n, 3);
      chk("arst.notes_after", 32'(notes), 32'd1);
      repeat (5) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
